// File: rtl/ccm_ctr_feed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccm_ctr_feed: serialises 128-bit payload blocks MSB-first into WIDTH-bit |
// | words for the CCM CTR stream interface.                  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module ccm_ctr_feed #(
  parameter int WIDTH     = 8,
  parameter int WIDTH_BLK = 128,
  parameter int WIDTH_LEN = 16
) (
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic                 abort,
  input  logic                 pkt_start,
  input  logic [WIDTH_LEN-1:0] pkt_len,
  input  logic [WIDTH_BLK-1:0] blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic                 ccm_ready,
  output logic [WIDTH-1:0]     input_data,
  output logic                 input_en,
  output logic                 input_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);

  localparam int BLK_WORDS = WIDTH_BLK / WIDTH;
  localparam int IDX_W     = $clog2(BLK_WORDS) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_SEND     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH_LEN-1:0] r_rem, w_rem_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [WIDTH_BLK-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0]     r_data, w_data_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_busy;
  logic [IDX_W-1:0]     w_blk_idx;

  // Words to take from the next block: a short final block stops at pkt_len.
  always_comb begin
    w_blk_idx = (r_rem >= WIDTH_LEN'(BLK_WORDS)) ? IDX_W'(BLK_WORDS) : IDX_W'(r_rem);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_en_nxt    = 1'b0;
    w_last_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
      w_idx_nxt   = '0;
      w_shift_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pkt_start) begin
            if (pkt_len != '0) begin
              w_rem_nxt   = pkt_len;
              w_state_nxt = S_WAIT_BLK;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        S_WAIT_BLK: begin
          if (blk_valid) begin
            w_shift_nxt = blk_data;
            w_idx_nxt   = w_blk_idx;
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          if (ccm_ready) begin
            w_data_nxt  = r_shift[WIDTH_BLK-1 -: WIDTH];
            w_en_nxt    = 1'b1;
            w_last_nxt  = (r_rem == WIDTH_LEN'(1));
            w_shift_nxt = r_shift << WIDTH;
            w_rem_nxt   = r_rem - WIDTH_LEN'(1);
            w_idx_nxt   = r_idx - IDX_W'(1);
            if (r_rem == WIDTH_LEN'(1)) begin
              w_state_nxt = S_DONE;
            end else if (r_idx == IDX_W'(1)) begin
              w_state_nxt = S_WAIT_BLK;
            end
          end
        end
        S_DONE: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_en    <= w_en_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign blk_ready  = (r_state == S_WAIT_BLK);
  assign input_data = r_data;
  assign input_en   = r_en;
  assign input_last = r_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_len    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ccm_ctr_feed.sv
`default_nettype none
// Bench for ccm_ctr_feed: expected word stream is the first pkt_len bytes of
// the supplied blocks; a compare process checks every cycle after the edge.
module tb_ccm_ctr_feed;

  logic         clk;
  logic         kill_n;
  logic         abort;
  logic         pkt_start;
  logic [15:0]  pkt_len;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         ccm_ready;
  logic [7:0]   input_data;
  logic         input_en;
  logic         input_last;
  logic         busy;
  logic         done;
  logic         err_len;

  ccm_ctr_feed #(.WIDTH(8), .WIDTH_BLK(128), .WIDTH_LEN(16)) dut (
    .clk(clk), .kill_n(kill_n), .abort(abort), .pkt_start(pkt_start),
    .pkt_len(pkt_len), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .ccm_ready(ccm_ready), .input_data(input_data),
    .input_en(input_en), .input_last(input_last), .busy(busy), .done(done),
    .err_len(err_len)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  bit         prev_last = 0;
  bit         in_pkt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  int         stamp[$];
  bit         brdy[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_data"}, 64'(input_data), 0);
    check({nm, "_en"}, 64'(input_en), 0);
    check({nm, "_last"}, 64'(input_last), 0);
    check({nm, "_busy"}, 64'(busy), 0);
    check({nm, "_done"}, 64'(done), 0);
    check({nm, "_err"}, 64'(err_len), 0);
    check({nm, "_blkrdy"}, 64'(blk_ready), 0);
  endtask

  // Per-cycle comparison against the expected word stream.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!kill_n) begin
      prev_last = 0;
    end else begin
      if (input_en) begin
        check("en_without_ready", 64'(ccm_ready), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(input_data), 64'hxx);
        end else begin
          logic [7:0] w;
          w = exp_q.pop_front();
          check("word", 64'(input_data), 64'(w));
          check("last", 64'(input_last), 64'(exp_q.size() == 0));
        end
        seen.push_back(input_data);
        stamp.push_back(cyc);
        brdy.push_back(blk_ready);
      end else begin
        check("last_without_en", 64'(input_last), 0);
      end
      check("done", 64'(done), 64'(prev_last && !abort));
      check("err_len", 64'(err_len), 64'(pkt_start && (pkt_len == 16'd0) && !abort && !in_pkt));
      prev_last = input_en && input_last;
      if (done) done_cnt++;
      if (err_len) err_cnt++;
    end
  end

  // One packet: cut >= 0 stops it after that many words (abort, or kill_n if use_kill).
  task automatic run_pkt(input int len, input bit seq, input int mode, input int vprob,
                         input int cut, input bit use_kill);
    logic [127:0] blocks[4];
    logic [127:0] tmp;
    int nblk, k, s0, dc0, post;
    bit fin, cut_done, took;
    nblk = (len + 15) / 16;
    for (int b = 0; b < 4; b++) begin
      tmp = {$urandom, $urandom, $urandom, $urandom};
      if (seq) for (int j = 0; j < 16; j++) tmp[127-8*j -: 8] = 8'(16*b + j);
      blocks[b] = tmp;
    end
    for (int i = 0; i < len; i++) begin
      tmp = blocks[i/16];
      exp_q.push_back(tmp[127-8*(i%16) -: 8]);
    end
    s0 = seen.size(); dc0 = done_cnt; k = 0; post = 0; fin = 0; cut_done = 0;
    @(negedge clk);
    pkt_start = 1'b1; pkt_len = 16'(len); in_pkt = 1;
    @(negedge clk);
    pkt_start = 1'b0; pkt_len = 16'($urandom);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (cut_done ? (post >= 4) : (done_cnt != dc0)) begin
        fin = 1;
        break;
      end
      if (cut_done) post++;
      case (mode)
        0: ccm_ready = 1'b1;
        1: ccm_ready = (t % 3 == 0);
        default: ccm_ready = 1'($urandom);
      endcase
      blk_valid = (k < nblk) && ($urandom_range(99) < vprob);
      blk_data  = blocks[(k < nblk) ? k : 0];
      pkt_start = (mode == 2) && ($urandom_range(15) == 0);
      pkt_len   = 16'($urandom_range(3));
      abort     = 1'b0;
      if (!cut_done && cut >= 0 && (seen.size() - s0) == cut) begin
        cut_done = 1; exp_q.delete(); blk_valid = 1'b0; pkt_start = 1'b0;
        if (use_kill) begin
          #2 kill_n = 1'b0;
          #1 check_all_zero("kill_async");
          in_pkt = 0;
          @(posedge clk);
          #2 kill_n = 1'b1;
          continue;
        end
        abort = 1'b1;
      end
      took = blk_valid && blk_ready;
      @(posedge clk);
      if (took) k++;
    end
    pkt_start = 1'b0; blk_valid = 1'b0; abort = 1'b0;
    check("pkt_finished", 64'(fin), 1);
    check("done_count", 64'(done_cnt - dc0), (cut < 0) ? 1 : 0);
    check("words_left", 64'(exp_q.size()), 0);
    check("busy_after", 64'(busy), 0);
    check("word_count", 64'(seen.size() - s0), (cut < 0) ? 64'(len) : 64'(cut));
    exp_q.delete();
    in_pkt = 0;
  endtask

  initial begin
    int s0, e0;
    kill_n = 1'b0; abort = 1'b0; pkt_start = 1'b0; pkt_len = '0;
    blk_data = '0; blk_valid = 1'b0; ccm_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    kill_n = 1'b1;
    repeat (2) @(negedge clk);

    s0 = seen.size();
    run_pkt(16, 1, 0, 100, -1, 0);
    check("t1_first", 64'(seen[s0]), 64'h00);
    check("t1_last", 64'(seen[s0+15]), 64'h0F);
    check("t1_back2back", 64'(stamp[s0+15] - stamp[s0]), 15);

    s0 = seen.size();
    run_pkt(20, 1, 0, 100, -1, 0);
    check("t2_last", 64'(seen[s0+19]), 64'h13);
    check("t2_gap", 64'(stamp[s0+16] - stamp[s0+15]), 2);
    check("t2_gap_blkrdy", 64'(brdy[s0+15]), 1);

    s0 = seen.size();
    run_pkt(16, 1, 1, 100, -1, 0);
    check("t3_last", 64'(seen[s0+15]), 64'h0F);

    e0 = err_cnt; s0 = seen.size();
    @(negedge clk);
    pkt_start = 1'b1; pkt_len = 16'd0;
    @(negedge clk);
    pkt_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("zlen_busy", 64'(busy), 0);
      check("zlen_blkrdy", 64'(blk_ready), 0);
    end
    check("zlen_err_count", 64'(err_cnt - e0), 1);
    check("zlen_words", 64'(seen.size() - s0), 0);

    run_pkt(16, 1, 0, 100, 5, 0);
    s0 = seen.size();
    run_pkt(4, 1, 0, 100, -1, 0);
    check("post_abort_w3", 64'(seen[s0+3]), 64'h03);

    run_pkt(32, 1, 0, 100, 7, 1);
    run_pkt(16, 0, 0, 100, -1, 0);

    for (int n = 0; n < 15; n++) begin
      run_pkt($urandom_range(1, 40), 0, $urandom_range(0, 2), $urandom_range(40, 100), -1, 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccm_ctr_feed.md
Name: ccm_ctr_feed

Overview:
Transmit-side feeder for the CCM CTR datapath. It accepts a packet byte length and a sequence of 128-bit payload blocks from upstream through a valid/ready handshake. It serialises the blocks MSB-first into WIDTH-bit words on the input_data/input_en/input_last byte-stream interface of the CTR block, and it obeys that block's ready indication.

Parameters:
WIDTH, 8, stream word width in bits; must divide WIDTH_BLK
WIDTH_BLK, 128, upstream block width in bits (one AES block)
WIDTH_LEN, 16, width of the packet length field, counted in WIDTH-bit words

Ports:
clk  input  1  clock, rising edge
kill_n  input  1  asynchronous active-low reset
abort  input  1  synchronous active-high packet abort
pkt_start  input  1  start pulse; pkt_len sampled on the same cycle
pkt_len  input  WIDTH_LEN  packet length in words
blk_data  input  WIDTH_BLK  payload block; word 0 = blk_data[WIDTH_BLK-1 -: WIDTH]
blk_valid  input  1  blk_data valid
blk_ready  output  1  feeder accepts a block this cycle
ccm_ready  input  1  CTR block can take a word (driven from its out_ready)
input_data  output  WIDTH  stream word to CTR block
input_en  output  1  input_data valid strobe
input_last  output  1  marks final word of packet, only with input_en
busy  output  1  packet in progress (state != IDLE)
done  output  1  one-cycle pulse after the last word is sent
err_len  output  1  one-cycle pulse: pkt_start with pkt_len == 0

Behaviour:
- Reset: asynchronous on kill_n low. All outputs go to 0, state = IDLE, counters and the shift register are cleared. Reset mid-packet drops the packet silently, with no input_last and no done.
- All outputs are registered except blk_ready, which is a decode of state (1 only in WAIT_BLK).
- BLK_WORDS = WIDTH_BLK/WIDTH. Counters: rem (WIDTH_LEN bits) counts words left in the packet; idx (log2(BLK_WORDS)+1 bits) counts words left in the current block.
- FSM states: IDLE, WAIT_BLK, SEND, DONE.
- IDLE:
  - pkt_start with pkt_len != 0: rem <= pkt_len, go to WAIT_BLK.
  - pkt_start with pkt_len == 0: err_len = 1 for the next cycle, stay in IDLE.
- WAIT_BLK: on blk_valid & blk_ready, the shift register <= blk_data, idx <= min(rem, BLK_WORDS), go to SEND.
- SEND: on each edge with ccm_ready = 1:
  - input_data <= shift top word; input_en <= 1; input_last <= (rem == 1).
  - Shift left by WIDTH; rem--, idx--.
  - If rem becomes 0, go to DONE. Else if idx becomes 0, go to WAIT_BLK.
- SEND with ccm_ready = 0: input_en <= 0 and input_last <= 0. input_data holds; no word is lost or duplicated.
- input_en is a one-cycle strobe per word. With ccm_ready held high and blk_valid held high, a packet has one idle cycle between blocks, spent in WAIT_BLK.
- Latency: block accepted at edge N gives the first input_en at edge N+1 if ccm_ready was 1 at that edge.
- DONE: done = 1 for one cycle, input_en <= 0, go to IDLE.
- Partial final block: words beyond pkt_len are discarded, never emitted.
- pkt_start outside IDLE is ignored; pkt_len changes mid-packet are ignored.
- abort (any state except IDLE):
  - Next cycle: state = IDLE, input_en = 0, input_last = 0, no done, counters cleared.
  - abort has priority over every same-cycle event, including pkt_start in IDLE, which is then ignored.
- rem is unsigned and never wraps, because it only decrements while nonzero.

Test Plan:
- pkt_len=16, one block 0x000102...0F, ccm_ready=1: 16 consecutive input_en words 00..0F, input_last only on 0F, done pulse on the following cycle, busy=0 after.
- pkt_len=20, blocks 00..0F then 10..1F: words 00..13 emitted, input_last on 13, one-cycle gap with blk_ready=1 between 0F and 10, words 14..1F never emitted.
- pkt_len=16, ccm_ready toggled 1,0,0,1,... for the whole packet: input_en only on edges following ccm_ready=1, sequence exactly 00..0F with no repeats.
- pkt_start with pkt_len=0: err_len pulses once, busy stays 0, blk_ready stays 0, no input_en.
- pkt_len=16, abort asserted after 5 words: input_en=0 next cycle, no input_last, no done. A following pkt_len=4 packet emits 4 words normally with input_last on word 4.
- kill_n pulsed low mid-packet, asynchronously between edges: all outputs 0 immediately. After release, busy=0 and a new packet runs correctly.
